// File: rtl/mdu_param.sv
// -----------------------------------------------------------------------------
// mdu_param - multiply/divide unit with HI/LO accumulator registers.
//
// Long operations (mult, multu, madd, maddu, msub, msubu, div, divu) are
// launched with start while the unit is idle and no flush is requested. The
// operands and the operation are captured, busy is raised for a fixed number
// of cycles, and HI/LO are written at the edge that ends the last busy cycle.
// mthi/mtlo write HI/LO directly when idle; mfhi/mflo need no state change
// because HI/LO are always visible on the outputs.
//
// Ports:
//   clk      - single clock, rising edge
//   reset    - synchronous, active-high reset
//   req      - exception/interrupt flush; blocks acceptance this cycle only
//   in_a     - operand A (rs)
//   in_b     - operand B (rt)
//   MDUOp    - operation code (0 none .. 12 msubu, 13-15 none)
//   start    - launch strobe for long operations
//   data_hi  - current HI register
//   data_lo  - current LO register
//   busy     - long operation in flight
// -----------------------------------------------------------------------------
module mdu_param #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       MDUOp,
    input  logic             start,
    output logic [WIDTH-1:0] data_hi,
    output logic [WIDTH-1:0] data_lo,
    output logic             busy
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam int W2         = 2 * WIDTH;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    // Operations that occupy the unit for several cycles.
    function automatic logic is_long_op(input logic [3:0] op);
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_long_op = 1'b1;
            default:                              is_long_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        case (op)
            OP_DIV, OP_DIVU: is_div_op = 1'b1;
            default:         is_div_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        case (op)
            OP_MULT, OP_MADD, OP_MSUB, OP_DIV: is_signed_op = 1'b1;
            default:                           is_signed_op = 1'b0;
        endcase
    endfunction

    // State registers.
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    // Datapath intermediates.
    logic             op_signed_s;
    logic             neg_a_s;
    logic             neg_b_s;
    logic [W2-1:0]    ext_a_s;
    logic [W2-1:0]    ext_b_s;
    logic [W2-1:0]    prod_s;
    logic [W2-1:0]    hilo_s;
    logic [W2-1:0]    result_s;
    logic [WIDTH-1:0] mag_a_s;
    logic [WIDTH-1:0] mag_b_s;
    logic [WIDTH-1:0] quot_mag_s;
    logic [WIDTH-1:0] rem_mag_s;
    logic [WIDTH-1:0] quot_s;
    logic [WIDTH-1:0] rem_s;
    logic             accept_s;

    assign data_hi = hi_q;
    assign data_lo = lo_q;
    assign busy    = busy_q;

    // Result of the captured operation, evaluated from the latched operands.
    always_comb begin
        op_signed_s = is_signed_op(op_q);
        if (op_signed_s) begin
            ext_a_s = {{WIDTH{a_q[WIDTH-1]}}, a_q};
            ext_b_s = {{WIDTH{b_q[WIDTH-1]}}, b_q};
        end else begin
            ext_a_s = {{WIDTH{1'b0}}, a_q};
            ext_b_s = {{WIDTH{1'b0}}, b_q};
        end
        // Low 2*WIDTH bits of the extended product are the exact product.
        prod_s = ext_a_s * ext_b_s;

        // Signed division on magnitudes: the most negative dividend keeps its
        // bit pattern when negated, which is also its correct unsigned magnitude,
        // so MIN / -1 yields MIN with remainder 0 without special casing.
        neg_a_s = op_signed_s & a_q[WIDTH-1];
        neg_b_s = op_signed_s & b_q[WIDTH-1];
        if (neg_a_s) begin
            mag_a_s = {WIDTH{1'b0}} - a_q;
        end else begin
            mag_a_s = a_q;
        end
        if (neg_b_s) begin
            mag_b_s = {WIDTH{1'b0}} - b_q;
        end else begin
            mag_b_s = b_q;
        end
        if (mag_b_s != {WIDTH{1'b0}}) begin
            quot_mag_s = mag_a_s / mag_b_s;
            rem_mag_s  = mag_a_s % mag_b_s;
        end else begin
            quot_mag_s = {WIDTH{1'b0}};
            rem_mag_s  = {WIDTH{1'b0}};
        end
        if (neg_a_s ^ neg_b_s) begin
            quot_s = {WIDTH{1'b0}} - quot_mag_s;
        end else begin
            quot_s = quot_mag_s;
        end
        if (neg_a_s) begin
            rem_s = {WIDTH{1'b0}} - rem_mag_s;
        end else begin
            rem_s = rem_mag_s;
        end

        hilo_s = {hi_q, lo_q};
        case (op_q)
            OP_MULT, OP_MULTU: result_s = prod_s;
            OP_MADD, OP_MADDU: result_s = hilo_s + prod_s;
            OP_MSUB, OP_MSUBU: result_s = hilo_s - prod_s;
            OP_DIV, OP_DIVU: begin
                // A zero divisor leaves HI/LO untouched.
                if (b_q != {WIDTH{1'b0}}) begin
                    result_s = {rem_s, quot_s};
                end else begin
                    result_s = hilo_s;
                end
            end
            default: result_s = hilo_s;
        endcase
    end

    // Next-state logic: accept, count down, commit, and direct HI/LO moves.
    always_comb begin
        hi_d     = hi_q;
        lo_d     = lo_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        accept_s = start & is_long_op(MDUOp) & ~busy_q & ~req;

        if (busy_q) begin
            // In flight: inputs are ignored, req does not abort.
            if (cnt_q == CNT_LAST) begin
                hi_d  = result_s[W2-1:WIDTH];
                lo_d  = result_s[WIDTH-1:0];
                cnt_d = {CNT_W{1'b0}};
                op_d  = OP_NONE;
            end else begin
                cnt_d = cnt_q - CNT_LAST;
            end
        end else if (accept_s) begin
            a_d  = in_a;
            b_d  = in_b;
            op_d = MDUOp;
            if (is_div_op(MDUOp)) begin
                cnt_d = DIV_LOAD;
            end else begin
                cnt_d = MULT_LOAD;
            end
        end else if (!req && MDUOp == OP_MTHI) begin
            hi_d = in_a;
        end else if (!req && MDUOp == OP_MTLO) begin
            lo_d = in_a;
        end else begin
            cnt_d = cnt_q;
        end

        busy_d = (cnt_d != {CNT_W{1'b0}});
    end

    // State update with synchronous reset dominating every other action.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q   <= {WIDTH{1'b0}};
            lo_q   <= {WIDTH{1'b0}};
            a_q    <= {WIDTH{1'b0}};
            b_q    <= {WIDTH{1'b0}};
            op_q   <= OP_NONE;
            cnt_q  <= {CNT_W{1'b0}};
            busy_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            a_q    <= a_d;
            b_q    <= b_d;
            op_q   <= op_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: tb/tb_mdu_param.sv
// -----------------------------------------------------------------------------
// tb_mdu_param - self-checking bench for mdu_param.
// A 32-bit instance with default timing is compared every cycle against a
// behavioural model that computes results with 64-bit integer arithmetic at
// accept time. A 16-bit, single-cycle multiply instance is checked directly.
// -----------------------------------------------------------------------------
module tb_mdu_param;

    logic        clk;
    logic        reset;
    logic        req;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  op;
    logic        start;
    logic [31:0] data_hi;
    logic [31:0] data_lo;
    logic        busy;

    logic        req16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic [3:0]  op16;
    logic        start16;
    logic [15:0] hi16;
    logic [15:0] lo16;
    logic        busy16;

    int n_checks;
    int n_fail;

    // Reference model state.
    logic [31:0] mdl_hi;
    logic [31:0] mdl_lo;
    int          mdl_left;
    logic [63:0] mdl_pend;
    logic        mdl_pv;

    mdu_param u_dut (
        .clk(clk), .reset(reset), .req(req), .in_a(in_a), .in_b(in_b),
        .MDUOp(op), .start(start), .data_hi(data_hi), .data_lo(data_lo),
        .busy(busy)
    );

    mdu_param #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(10)) u_dut16 (
        .clk(clk), .reset(reset), .req(req16), .in_a(a16), .in_b(b16),
        .MDUOp(op16), .start(start16), .data_hi(hi16), .data_lo(lo16),
        .busy(busy16)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural result of a long op from the rules, using 64-bit integers.
    function automatic logic [63:0] calc(input logic [3:0] o, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] hilo,
                                         output logic ok);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] up;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        up   = {32'd0, a} * {32'd0, b};
        ok   = 1'b1;
        calc = hilo;
        case (o)
            4'd1:  calc = sa * sb;
            4'd2:  calc = up;
            4'd9:  calc = hilo + (sa * sb);
            4'd10: calc = hilo + up;
            4'd11: calc = hilo - (sa * sb);
            4'd12: calc = hilo - up;
            4'd3: begin
                if (b == 32'd0) begin
                    ok = 1'b0;
                end else begin
                    q    = sa / sb;
                    r    = sa % sb;
                    calc = {r[31:0], q[31:0]};
                end
            end
            4'd4: begin
                if (b == 32'd0) begin
                    ok = 1'b0;
                end else begin
                    calc = {a % b, a / b};
                end
            end
            default: ok = 1'b0;
        endcase
    endfunction

    function automatic logic is_long(input logic [3:0] o);
        return (o inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd10, 4'd11, 4'd12});
    endfunction

    // One clock edge: advance the model with the inputs present at the edge,
    // then compare the 32-bit instance against it.
    task automatic step();
        logic ok;
        logic [63:0] res;
        @(posedge clk);
        if (reset) begin
            mdl_hi = 32'd0; mdl_lo = 32'd0; mdl_left = 0; mdl_pv = 1'b0;
        end else if (mdl_left > 0) begin
            mdl_left--;
            if (mdl_left == 0 && mdl_pv) begin
                mdl_hi = mdl_pend[63:32];
                mdl_lo = mdl_pend[31:0];
            end
        end else if (start && is_long(op) && !req) begin
            res      = calc(op, in_a, in_b, {mdl_hi, mdl_lo}, ok);
            mdl_pend = res;
            mdl_pv   = ok;
            mdl_left = (op == 4'd3 || op == 4'd4) ? 10 : 5;
        end else if (!req && op == 4'd7) begin
            mdl_hi = in_a;
        end else if (!req && op == 4'd8) begin
            mdl_lo = in_a;
        end
        #1;
        chk("busy", {63'd0, busy}, {63'd0, (mdl_left > 0)});
        chk("hi", {32'd0, data_hi}, {32'd0, mdl_hi});
        chk("lo", {32'd0, data_lo}, {32'd0, mdl_lo});
    endtask

    task automatic drive(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic st, input logic rq);
        op = o; in_a = a; in_b = b; start = st; req = rq;
    endtask

    // Launch a long op and run until the model says it has committed.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        drive(o, a, b, 1'b1, 1'b0);
        step();
        drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 20 && mdl_left > 0; i++) step();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        n_checks = 0; n_fail = 0;
        mdl_hi = 32'd0; mdl_lo = 32'd0; mdl_left = 0; mdl_pend = 64'd0; mdl_pv = 1'b0;
        reset = 1'b1;
        drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        req16 = 1'b0; a16 = 16'd0; b16 = 16'd0; op16 = 4'd0; start16 = 1'b0;
        step();
        step();
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_hi", {32'd0, data_hi}, 64'd0);
        chk("rst_lo", {32'd0, data_lo}, 64'd0);
        chk("rst_busy16", {63'd0, busy16}, 64'd0);
        reset = 1'b0;

        // Signed multiply, default widths, busy counted cycle by cycle.
        drive(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0);
        a16 = 16'hFFFE; b16 = 16'd3; op16 = 4'd1; start16 = 1'b1;
        step();
        chk("m16_busy1", {63'd0, busy16}, 64'd1);
        drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        op16 = 4'd0; start16 = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("mult_busy_seq", {63'd0, busy}, {63'd0, (i < 5)});
            if (i == 1) begin
                chk("m16_busy_end", {63'd0, busy16}, 64'd0);
                chk("m16_hi", {48'd0, hi16}, 64'h0000_0000_0000_FFFF);
                chk("m16_lo", {48'd0, lo16}, 64'h0000_0000_0000_FFFA);
            end
        end
        chk("mult_hi", {32'd0, data_hi}, 64'h0000_0000_FFFF_FFFF);
        chk("mult_lo", {32'd0, data_lo}, 64'h0000_0000_FFFF_FFFA);

        // Division, unsigned then signed.
        run_op(4'd4, 32'd7, 32'd2);
        chk("divu_lo", {32'd0, data_lo}, 64'd3);
        chk("divu_hi", {32'd0, data_hi}, 64'd1);
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2);
        chk("div_lo", {32'd0, data_lo}, 64'h0000_0000_FFFF_FFFD);
        chk("div_hi", {32'd0, data_hi}, 64'h0000_0000_FFFF_FFFF);
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("divmin_lo", {32'd0, data_lo}, 64'h0000_0000_8000_0000);
        chk("divmin_hi", {32'd0, data_hi}, 64'd0);

        // Accumulate with carry/borrow across HI/LO.
        drive(4'd7, 32'd1, 32'd0, 1'b0, 1'b0); step();
        drive(4'd8, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0); step();
        run_op(4'd10, 32'd1, 32'd1);
        chk("maddu_hi", {32'd0, data_hi}, 64'd2);
        chk("maddu_lo", {32'd0, data_lo}, 64'd0);
        run_op(4'd12, 32'd1, 32'd1);
        chk("msubu_hi", {32'd0, data_hi}, 64'd1);
        chk("msubu_lo", {32'd0, data_lo}, 64'h0000_0000_FFFF_FFFF);

        // Divide by zero keeps HI/LO; mtlo during busy is ignored.
        drive(4'd7, 32'h11, 32'd0, 1'b0, 1'b0); step();
        drive(4'd8, 32'h22, 32'd0, 1'b0, 1'b0); step();
        drive(4'd3, 32'd5, 32'd0, 1'b1, 1'b0); step();
        drive(4'd8, 32'd5, 32'd0, 1'b0, 1'b0); step();
        drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step();
        chk("div0_busy", {63'd0, busy}, 64'd0);
        chk("div0_hi", {32'd0, data_hi}, 64'h11);
        chk("div0_lo", {32'd0, data_lo}, 64'h22);

        // Flush blocks acceptance but not an op in flight.
        drive(4'd1, 32'd2, 32'd3, 1'b1, 1'b1); step();
        chk("req_block", {63'd0, busy}, 64'd0);
        drive(4'd1, 32'd2, 32'd3, 1'b1, 1'b0); step();
        drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step();
        chk("req_mid_lo", {32'd0, data_lo}, 64'd6);
        chk("req_mid_hi", {32'd0, data_hi}, 64'd0);

        // Reset in busy cycle 3 discards the op.
        drive(4'd1, 32'd3, 32'd3, 1'b1, 1'b0); step();
        drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        step(); step();
        reset = 1'b1; step(); reset = 1'b0;
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_lo", {32'd0, data_lo}, 64'd0);
        for (int i = 0; i < 5; i++) step();
        chk("rst_no_commit", {32'd0, data_lo}, 64'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            op    = 4'($urandom_range(0, 15));
            start = ($urandom_range(0, 3) != 0);
            req   = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 199) == 0);
            in_a  = pick();
            in_b  = pick();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_param.md
MDU_PARAM -- requirements
Module: mdu_param

Interface
REQ-001 Parameter WIDTH, default 32: operand width and width of each of HI and LO; SHALL be >= 8.
REQ-002 Parameter MULT_CYCLES, default 5: busy duration of mult/multu/madd/maddu/msub/msubu; SHALL be >= 1.
REQ-003 Parameter DIV_CYCLES, default 10: busy duration of div/divu; SHALL be >= 1.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  1  exception/interrupt flush; blocks acceptance of the op presented this cycle.
REQ-007 in_a  input  WIDTH  operand A (rs, forwarded).
REQ-008 in_b  input  WIDTH  operand B (rt, forwarded).
REQ-009 MDUOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 maddu, 11 msub, 12 msubu; 13-15 treated as none.
REQ-010 start  input  1  launch strobe for long ops (1-4, 9-12).
REQ-011 data_hi  output  WIDTH  current HI register.
REQ-012 data_lo  output  WIDTH  current LO register.
REQ-013 busy  output  1  long op in flight.

Function
REQ-014 Accept condition: long op accepted at edge t iff start=1, MDUOp in {1-4,9-12}, busy=0, req=0, reset=0.
REQ-015 On accept: latch op, in_a, in_b and a down-counter = N (MULT_CYCLES or DIV_CYCLES); busy=1 from cycle t+1 for exactly N cycles.
REQ-016 HI/LO SHALL update at the edge ending the last busy cycle; busy=0 in the following cycle; data_hi/data_lo show new values in that same cycle.
REQ-017 Back-to-back: new accept permitted in first cycle busy=0; no idle gap required.
REQ-018 start while busy=1: ignored, no effect on in-flight op or HI/LO.
REQ-019 mthi (7)/mtlo (8): when busy=0, req=0, HI (resp. LO) := in_a at the edge; start not required; ignored while busy=1 or req=1.
REQ-020 mfhi/mflo (5/6): no state change; data_hi/data_lo always drive HI/LO combinationally from registers.
REQ-021 req=1 SHALL NOT abort an op already in flight; it completes and commits normally.
REQ-022 mult: {HI,LO} := signed in_a × signed in_b, full 2·WIDTH product; multu: unsigned.
REQ-023 madd/maddu: {HI,LO} := {HI,LO} + product (signed/unsigned), modulo 2^(2·WIDTH); msub/msubu: {HI,LO} - product, modulo 2^(2·WIDTH); HI/LO operand is the value at accept time (unchangeable while busy, see REQ-019).
REQ-024 div: LO := quotient truncated toward zero, HI := remainder with sign of dividend; divu: unsigned quotient/remainder.
REQ-025 Divisor = 0: op still busy DIV_CYCLES; HI and LO SHALL remain unchanged.
REQ-026 div with in_a = -2^(WIDTH-1), in_b = -1: LO := -2^(WIDTH-1) (truncated), HI := 0; no trap.
REQ-027 Counter width = ceil(log2(max(MULT_CYCLES,DIV_CYCLES)+1)); no wrap permitted.

Reset
REQ-028 reset=1 at an edge: HI=0, LO=0, busy=0, counter=0, latched op cleared; any in-flight op discarded without commit.
REQ-029 reset dominates start, mthi/mtlo and completion in the same cycle.
REQ-030 First accept possible at the first edge with reset=0.

Verification
REQ-031 Defaults; mult a=0xFFFFFFFE (-2), b=3, start at edge 0 -> busy high cycles 1-5, cycle 6: HI=0xFFFFFFFF, LO=0xFFFFFFFA, busy=0.
REQ-032 divu a=7, b=2 -> busy 10 cycles, then LO=3, HI=1; follow with div a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-033 mthi 0x1, mtlo 0xFFFFFFFF, then maddu a=1, b=1 -> HI=0x2, LO=0x0; then msubu a=1, b=1 -> HI=0x1, LO=0xFFFFFFFF.
REQ-034 div b=0 with HI=0x11, LO=0x22 -> busy 10 cycles, HI=0x11, LO=0x22; mtlo 0x5 issued during busy -> ignored.
REQ-035 start with req=1 -> not accepted, busy stays 0; req=1 asserted mid-mult -> result still committed; reset asserted in busy cycle 3 -> busy=0, HI=LO=0 next cycle, no later commit.
REQ-036 Re-run REQ-031 with WIDTH=16, MULT_CYCLES=1: a=0xFFFE, b=3 -> busy exactly 1 cycle, HI=0xFFFF, LO=0xFFFA.
